// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: fetch handshake, data load/store port and the
// byte-wide synchronous RAM bus. The controller uses the slave modport.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // Instruction-fetch handshake
    logic              inst_fe;
    logic [ADDR_W-1:0] inst_fpc;
    logic [31:0]       inst_o;
    logic              inst_ok;
    logic [ADDR_W-1:0] inst_pc;
    // Data load/store port
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ok;
    // Byte-wide RAM bus and IO back-pressure
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              io_buffer_full;

    modport slave (
        input  inst_fe, inst_fpc, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               ram_din, io_buffer_full,
        output inst_o, inst_ok, inst_pc, mem_rdata, mem_ok, ram_dout, ram_a, ram_wr
    );

    modport master (
        output inst_fe, inst_fpc, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               ram_din, io_buffer_full,
        input  inst_o, inst_ok, inst_pc, mem_rdata, mem_ok, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and data loads/stores onto a
// byte-wide synchronous RAM. Data requests win over fetches.
// Optional feature macro: UART_FULL_STALL_EN -- IO-region stores wait for
// io_buffer_full to drop before each byte write.
module mem_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [1:0]  IO_MASK = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STORE,
        S_DONE
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0]    r_len,     w_len_nxt;
    logic [ADDR_W-1:0]   r_base,    w_base_nxt;
    logic [DATA_W-1:0]   r_wdata,   w_wdata_nxt;
    logic [DATA_W-1:0]   r_buf,     w_buf_nxt;
    logic                r_is_fetch, w_is_fetch_nxt;

    logic [DATA_W-1:0]   r_inst_o;
    logic [ADDR_W-1:0]   r_inst_pc;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_inst_ok;
    logic                r_mem_ok;
    logic [ADDR_W-1:0]   r_ram_a,    w_ram_a_nxt;
    logic [7:0]          r_ram_dout, w_ram_dout_nxt;
    logic                r_ram_wr,   w_ram_wr_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_is_io;
    logic                w_stall;

    // Byte count of an access: byte, half, word (sel 11 behaves as word)
    function automatic logic [CNT_W-1:0] len_of(input logic [1:0] sel);
        case (sel)
            2'b00:   len_of = CNT_W'(1);
            2'b01:   len_of = CNT_W'(2);
            default: len_of = CNT_W'(4);
        endcase
    endfunction

    // IO-region store back-pressure
    assign w_is_io = (r_base[17:16] == IO_MASK);
`ifdef UART_FULL_STALL_EN
    assign w_stall = (r_state == S_STORE) && w_is_io && bus.io_buffer_full;
`else
    logic [1:0] w_unused_io;
    assign w_unused_io = {w_is_io, bus.io_buffer_full};
    assign w_stall     = 1'b0;
`endif

    // Next-state, datapath and next-output computation
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_base_nxt     = r_base;
        w_wdata_nxt    = r_wdata;
        w_buf_nxt      = r_buf;
        w_is_fetch_nxt = r_is_fetch;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_buf_nxt = '0;
                if (bus.mem_req) begin
                    w_state_nxt    = bus.mem_we ? S_STORE : S_LOAD;
                    w_base_nxt     = bus.mem_addr;
                    w_len_nxt      = len_of(bus.mem_sel);
                    w_wdata_nxt    = bus.mem_wdata;
                    w_is_fetch_nxt = 1'b0;
                end else if (bus.inst_fe) begin
                    w_state_nxt    = S_FETCH;
                    w_base_nxt     = bus.inst_fpc;
                    w_len_nxt      = CNT_W'(4);
                    w_is_fetch_nxt = 1'b1;
                end
            end
            S_FETCH, S_LOAD: begin
                // byte cnt-1 was addressed last cycle and is on ram_din now
                if (r_cnt != '0) begin
                    w_buf_nxt[{2'(r_cnt - CNT_W'(1)), 3'b000} +: 8] = bus.ram_din;
                end
                if (r_cnt == r_len) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STORE: begin
                if (!w_stall) begin
                    if (r_cnt == r_len - CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt     = ((w_state_nxt == S_FETCH) || (w_state_nxt == S_LOAD) ||
                          (w_state_nxt == S_STORE)) && (w_cnt_nxt < w_len_nxt);
        w_ram_a_nxt    = w_busy_nxt ? (w_base_nxt + ADDR_W'(w_cnt_nxt)) : '0;
        w_ram_wr_nxt   = (w_state_nxt == S_STORE);
        w_ram_dout_nxt = w_ram_wr_nxt ? w_wdata_nxt[{2'(w_cnt_nxt), 3'b000} +: 8] : 8'h00;
        w_done_nxt     = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= CNT_W'(4);
            r_base      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_is_fetch  <= 1'b0;
            r_inst_o    <= '0;
            r_inst_pc   <= '0;
            r_mem_rdata <= '0;
            r_inst_ok   <= 1'b0;
            r_mem_ok    <= 1'b0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_base     <= w_base_nxt;
            r_wdata    <= w_wdata_nxt;
            r_buf      <= w_buf_nxt;
            r_is_fetch <= w_is_fetch_nxt;
            r_inst_ok  <= w_done_nxt && w_is_fetch_nxt;
            r_mem_ok   <= w_done_nxt && !w_is_fetch_nxt;
            r_ram_a    <= w_ram_a_nxt;
            r_ram_dout <= w_ram_dout_nxt;
            r_ram_wr   <= w_ram_wr_nxt;
            if (w_done_nxt && (r_state == S_FETCH)) begin
                r_inst_o  <= w_buf_nxt;
                r_inst_pc <= w_base_nxt;
            end
            if (w_done_nxt && (r_state == S_LOAD)) begin
                r_mem_rdata <= w_buf_nxt;
            end
        end
    end

    assign bus.inst_o    = r_inst_o;
    assign bus.inst_pc   = r_inst_pc;
    assign bus.inst_ok   = r_inst_ok;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.mem_ok    = r_mem_ok;
    assign bus.ram_a     = r_ram_a;
    assign bus.ram_dout  = r_ram_dout;
    // A stalled IO byte cycle must not strobe the RAM
    assign bus.ram_wr    = r_ram_wr & ~w_stall;
endmodule
